// File: rtl/sdp_ram_pkg.sv
// Shared constants and helpers for the simple dual-port RAM.
// Collision-mode encodings plus the lane-count helper used by the RAM and its bus interface.
package sdp_ram_pkg;

  localparam bit RD_OLD = 1'b0;
  localparam bit WR_NEW = 1'b1;

  function automatic int calc_nlane(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

endpackage

// File: rtl/sdp_ram_pipe_if.sv
// Write/read port bundle for sdp_ram_pipe; master drives requests, slave returns read data.
// No backpressure: every request is accepted on the edge it is presented.
interface sdp_ram_pipe_if
  import sdp_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANE_W = 4,
  parameter int ADDR_W = 3
);
  localparam int NLANE = calc_nlane(DATA_W, LANE_W);

  logic              write_en;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [NLANE-1:0]  write_mask;
  logic              read_en;
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic              addr_err;

  modport master (
    output write_en, write_addr, write_data, write_mask, read_en, read_addr,
    input  read_data, read_valid, addr_err
  );

  modport slave (
    input  write_en, write_addr, write_data, write_mask, read_en, read_addr,
    output read_data, read_valid, addr_err
  );
endinterface

// File: rtl/sdp_ram_rdpipe.sv
// Read-return pipeline: RD_LAT stages of {valid, data}, async clear, no backpressure.
// Each stage only loads data when its input is valid, so the output holds the last word read.
module sdp_ram_rdpipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_dat,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_dat
);
  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld;
      if (in_vld) dat_q[0] <= in_dat;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[RD_LAT-1];
  assign out_dat = dat_q[RD_LAT-1];
endmodule

// File: rtl/sdp_ram_pipe.sv
// Simple dual-port RAM with lane write mask, RD_LAT-cycle registered read and range flagging.
// Latency RD_LAT (1 or 2); no backpressure, every read_en yields exactly one read_valid.
module sdp_ram_pipe
  import sdp_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LANE_W    = 4,
  parameter int ADDR_W    = 3,
  parameter int DEPTH     = 8,
  parameter int RD_LAT    = 1,
  parameter bit WR_FIRST  = RD_OLD,
  parameter bit RESET_MEM = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  sdp_ram_pipe_if.slave bus
);
  localparam int NLANE = calc_nlane(DATA_W, LANE_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] pipe_dat;
  logic              pipe_vld;
  logic              wr_in;
  logic              rd_in;
  logic              wr_ok;
  logic              rd_ok;
  logic              hit;

  assign wr_in = int'(bus.write_addr) < DEPTH;
  assign rd_in = int'(bus.read_addr) < DEPTH;
  assign wr_ok = bus.write_en && wr_in;
  assign rd_ok = bus.read_en && rd_in;
  assign hit   = wr_ok && (bus.write_addr == bus.read_addr);

  assign old_word = mem[bus.write_addr];

  always_comb begin
    merged = old_word;
    for (int i = 0; i < NLANE; i++) begin
      if (bus.write_mask[i]) merged[i*LANE_W +: LANE_W] = bus.write_data[i*LANE_W +: LANE_W];
    end
  end

  // Out-of-range reads return zero rather than whatever the array index aliases to.
  always_comb begin
    rd_word = '0;
    if (rd_ok) rd_word = (WR_FIRST == WR_NEW && hit) ? merged : mem[bus.read_addr];
  end

  if (RESET_MEM) begin : g_mem_rst
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_ok) begin
        mem[bus.write_addr] <= merged;
      end
    end
  end else begin : g_mem_norst
    always_ff @(posedge clk) begin
      if (wr_ok) mem[bus.write_addr] <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.addr_err <= 1'b0;
    else        bus.addr_err <= (bus.write_en && !wr_in) || (bus.read_en && !rd_in);
  end

  sdp_ram_rdpipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (bus.read_en),
    .in_dat  (rd_word),
    .out_vld (pipe_vld),
    .out_dat (pipe_dat)
  );

  assign bus.read_valid = pipe_vld;
  assign bus.read_data  = pipe_dat;
endmodule

// File: tb/tb_sdp_ram_pipe.sv
// Drives two RAM configurations with identical stimulus: A (depth 8, 2-cycle, read-old)
// and B (depth 6, 1-cycle, write-first); directed vectors followed by a modelled random run.
module tb_sdp_ram_pipe;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       we, re;
  logic [2:0] wa, ra;
  logic [7:0] wd;
  logic [1:0] wm;
  int         n_chk = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  sdp_ram_pipe_if #(.DATA_W(8), .LANE_W(4), .ADDR_W(3)) ia ();
  sdp_ram_pipe_if #(.DATA_W(8), .LANE_W(4), .ADDR_W(3)) ib ();

  assign ia.write_en = we;  assign ib.write_en = we;
  assign ia.write_addr = wa; assign ib.write_addr = wa;
  assign ia.write_data = wd; assign ib.write_data = wd;
  assign ia.write_mask = wm; assign ib.write_mask = wm;
  assign ia.read_en = re;   assign ib.read_en = re;
  assign ia.read_addr = ra; assign ib.read_addr = ra;

  sdp_ram_pipe #(
    .DATA_W(8), .LANE_W(4), .ADDR_W(3), .DEPTH(8), .RD_LAT(2), .WR_FIRST(1'b0), .RESET_MEM(1'b1)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));

  sdp_ram_pipe #(
    .DATA_W(8), .LANE_W(4), .ADDR_W(3), .DEPTH(6), .RD_LAT(1), .WR_FIRST(1'b1), .RESET_MEM(1'b1)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [7:0] d, input logic e);
    chk({tag, "_a_vld"}, 32'(ia.read_valid), 32'(v));
    chk({tag, "_a_dat"}, 32'(ia.read_data), 32'(d));
    chk({tag, "_a_err"}, 32'(ia.addr_err), 32'(e));
  endtask

  task automatic chk_b(input string tag, input logic v, input logic [7:0] d, input logic e);
    chk({tag, "_b_vld"}, 32'(ib.read_valid), 32'(v));
    chk({tag, "_b_dat"}, 32'(ib.read_data), 32'(d));
    chk({tag, "_b_err"}, 32'(ib.addr_err), 32'(e));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lane_merge(input logic [7:0] old, input logic [7:0] nw,
                                            input logic [1:0] m);
    return {m[1] ? nw[7:4] : old[7:4], m[0] ? nw[3:0] : old[3:0]};
  endfunction

  logic [7:0] ma [8];
  logic [7:0] mb [6];
  logic       a_s0v, ea_vld, eb_vld, eb_err;
  logic [7:0] a_s0d, ea_dat, eb_dat, merged_b;

  initial begin
    rst_n = 1'b0;
    we = 1'b0; re = 1'b0; wa = '0; ra = '0; wd = '0; wm = '0;
    step(); step();
    chk_a("reset", 1'b0, 8'h00, 1'b0);
    chk_b("reset", 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    step();

    // Masked write: second write only replaces the low lane.
    we = 1'b1; wa = 3'd3; wd = 8'hAB; wm = 2'b11; step();
    wd = 8'h5C; wm = 2'b01; step();
    we = 1'b0; re = 1'b1; ra = 3'd3; step();
    chk_b("t2", 1'b1, 8'hAC, 1'b0);
    chk_a("t2_lat", 1'b0, 8'h00, 1'b0);
    re = 1'b0; step();
    chk_a("t2", 1'b1, 8'hAC, 1'b0);
    chk_b("t2_hold", 1'b0, 8'hAC, 1'b0);

    // Same-edge read/write collision on addr 5.
    we = 1'b1; wa = 3'd5; wd = 8'h11; wm = 2'b11; step();
    wd = 8'h22; re = 1'b1; ra = 3'd5; step();
    chk_b("t3_col", 1'b1, 8'h22, 1'b0);
    we = 1'b0; step();
    chk_a("t3_col", 1'b1, 8'h11, 1'b0);
    chk_b("t3_after", 1'b1, 8'h22, 1'b0);
    re = 1'b0; step();
    chk_a("t3_after", 1'b1, 8'h22, 1'b0);

    // Fill 0..7; B drops 6 and 7 and flags them.
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wa = 3'(i); wd = 8'hA0 + 8'(i); wm = 2'b11; step();
      chk_b($sformatf("t4_fill%0d", i), 1'b0, 8'h22, 1'(i >= 6));
      chk_a($sformatf("t4_fill%0d", i), 1'b0, 8'h22, 1'b0);
    end
    we = 1'b0;
    for (int k = 0; k < 10; k++) begin
      re = 1'(k < 8); ra = 3'(k); step();
      chk_b($sformatf("t4_str%0d", k), 1'(k < 8), (k < 6) ? 8'hA0 + 8'(k) : 8'h00,
            1'(k == 6 || k == 7));
      chk_a($sformatf("t4_str%0d", k), 1'(k >= 1 && k <= 8),
            (k == 0) ? 8'h22 : (k == 9) ? 8'hA7 : 8'hA0 + 8'(k - 1), 1'b0);
    end

    // Range: B sees both ports out of range on one edge.
    we = 1'b1; wa = 3'd6; wd = 8'hFF; wm = 2'b11; re = 1'b1; ra = 3'd7; step();
    chk_b("t5_both", 1'b1, 8'h00, 1'b1);
    chk_a("t5_both", 1'b0, 8'hA7, 1'b0);
    we = 1'b0; ra = 3'd0; step();
    chk_b("t5_pulse", 1'b1, 8'hA0, 1'b0);
    chk_a("t5_rd7", 1'b1, 8'hA7, 1'b0);
    ra = 3'd6; step();
    chk_b("t5_rd6", 1'b1, 8'h00, 1'b1);
    chk_a("t5_rd0", 1'b1, 8'hA0, 1'b0);
    re = 1'b0; step();
    chk_b("t5_idle", 1'b0, 8'h00, 1'b0);
    chk_a("t5_rd6", 1'b1, 8'hFF, 1'b0);

    // Zero-mask write is a no-op; then reset lands with a read in flight on A.
    we = 1'b1; wa = 3'd2; wd = 8'h33; wm = 2'b00; step();
    wa = 3'd7; re = 1'b1; ra = 3'd2; step();
    chk_b("t1_pre", 1'b1, 8'hA2, 1'b1);
    we = 1'b0; ra = 3'd1; step();
    chk_a("t1_nomask", 1'b1, 8'hA2, 1'b0);
    chk_b("t1_pre2", 1'b1, 8'hA1, 1'b0);
    rst_n = 1'b0; re = 1'b0;
    #1;
    chk_a("t1_async", 1'b0, 8'h00, 1'b0);
    chk_b("t1_async", 1'b0, 8'h00, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk_a("t1_flush", 1'b0, 8'h00, 1'b0);
    step();
    chk_a("t1_flush2", 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 10; k++) begin
      re = 1'(k < 8); ra = 3'(k); step();
      chk_b($sformatf("t1_clr%0d", k), 1'(k < 8), 8'h00, 1'(k == 6 || k == 7));
      chk_a($sformatf("t1_clr%0d", k), 1'(k >= 1 && k <= 8), 8'h00, 1'b0);
    end

    // Random traffic against a behavioural model; both memories are cleared here.
    for (int i = 0; i < 8; i++) ma[i] = 8'h00;
    for (int i = 0; i < 6; i++) mb[i] = 8'h00;
    a_s0v = 1'b0; a_s0d = 8'h00; ea_dat = 8'h00; eb_dat = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      we = 1'($urandom); re = 1'($urandom);
      wa = 3'($urandom); ra = 3'($urandom);
      wd = 8'($urandom); wm = 2'($urandom);

      ea_vld = a_s0v;
      if (a_s0v) ea_dat = a_s0d;
      a_s0v = re;
      if (re) a_s0d = ma[ra];
      if (we) ma[wa] = lane_merge(ma[wa], wd, wm);

      merged_b = (int'(wa) < 6) ? lane_merge(mb[wa], wd, wm) : 8'h00;
      eb_vld = re;
      eb_err = (we && int'(wa) >= 6) || (re && int'(ra) >= 6);
      if (re) begin
        if (int'(ra) >= 6)              eb_dat = 8'h00;
        else if (we && wa == ra)        eb_dat = merged_b;
        else                            eb_dat = mb[ra];
      end
      if (we && int'(wa) < 6) mb[wa] = merged_b;

      step();
      chk_a("t6_rnd", ea_vld, ea_dat, 1'b0);
      chk_b("t6_rnd", eb_vld, eb_dat, eb_err);
    end

    we = 1'b0; re = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
